// File: rtl/hilo_muldiv_unit.sv
// hilo_muldiv_unit
// Multi-cycle integer multiply/divide unit holding the architectural HI/LO
// pair. Ops: MULT/MULTU/DIV/DIVU/MADD/MADDU/MSUB/MSUBU plus MTHI/MTLO writes.
//
// Ports
//   i_clk, i_reset_n        rising-edge clock, async active-low reset
//   i_start, i_op[2:0]      launch op (000 MULT .. 111 MSUBU) in IDLE
//   i_rs_data, i_rt_data    multiplicand/dividend, multiplier/divisor
//   i_mt_hi, i_mt_lo        MTHI/MTLO strobes, data on i_mt_data
//   o_busy                  op in flight, pipeline must stall
//   o_done                  one-cycle pulse when HI/LO take a result
//   o_div_by_zero           last divide had a zero divisor
//   o_hi, o_lo              registered HI/LO
//
// Build option: define HILO_FAST_MUL_EN to compute multiply-class ops with a
// single-cycle combinational multiplier in FIX (latency 1). Divide timing is
// unaffected. Undefined: every op takes the 32-iteration path (latency 33).
module hilo_muldiv_unit (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        i_start,
  input  logic [2:0]  i_op,
  input  logic [31:0] i_rs_data,
  input  logic [31:0] i_rt_data,
  input  logic        i_mt_hi,
  input  logic        i_mt_lo,
  input  logic [31:0] i_mt_data,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_div_by_zero,
  output logic [31:0] o_hi,
  output logic [31:0] o_lo
);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX} state_t;

  state_t      r_state, w_next;
  logic [2:0]  r_op;
  logic [31:0] r_a;       // |rs| (raw rs for divide-by-zero)
  logic [31:0] r_b;       // |rt|
  logic [63:0] r_p;       // mul: {partial sum, multiplier}; div: {remainder, quotient}
  logic [63:0] r_acc;     // {HI,LO} snapshot for MADD*/MSUB*
  logic        r_neg_q;   // product / quotient sign
  logic        r_neg_r;   // remainder sign (dividend sign)
  logic        r_div0;
  logic [4:0]  r_cnt;
  logic [31:0] r_hi, r_lo;
  logic        r_done, r_dbz;

  // ---------------- launch decode ----------------
  logic        w_is_div, w_signed, w_rs_neg, w_rt_neg, w_div0, w_accept;
  logic [31:0] w_rs_abs, w_rt_abs;

  assign w_is_div = ~i_op[2] & i_op[1];
  assign w_signed = ~i_op[0];
  assign w_rs_neg = w_signed & i_rs_data[31];
  assign w_rt_neg = w_signed & i_rt_data[31];
  assign w_rs_abs = w_rs_neg ? (32'd0 - i_rs_data) : i_rs_data;
  assign w_rt_abs = w_rt_neg ? (32'd0 - i_rt_data) : i_rt_data;
  assign w_div0   = w_is_div & (i_rt_data == 32'd0);
  assign w_accept = (r_state == S_IDLE) & i_start;

  logic w_r_is_div;
  assign w_r_is_div = ~r_op[2] & r_op[1];

  // ---------------- FSM ----------------
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (i_start) begin
          if (w_div0) w_next = S_FIX;
`ifdef HILO_FAST_MUL_EN
          else if (!w_is_div) w_next = S_FIX;
`endif
          else w_next = S_CALC;
        end
      end
      S_CALC: if (r_cnt == 5'd31) w_next = S_FIX;
      S_FIX:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // ---------------- iteration step ----------------
  // Shift-add multiply: add multiplicand into the upper half when the
  // current multiplier LSB is set, then shift the whole pair right.
  logic [32:0] w_mul_sum;
  logic [63:0] w_mul_step;
  assign w_mul_sum  = {1'b0, r_p[63:32]} + {1'b0, r_a};
  assign w_mul_step = r_p[0] ? {w_mul_sum, r_p[31:1]} : {1'b0, r_p[63:1]};

  // Restoring divide: shift next dividend bit into the remainder and keep
  // the trial difference only when it did not borrow.
  logic [32:0] w_div_shift, w_div_trial;
  logic [63:0] w_div_step;
  assign w_div_shift = {r_p[63:32], r_p[31]};
  assign w_div_trial = w_div_shift - {1'b0, r_b};
  assign w_div_step  = w_div_trial[32] ? {w_div_shift[31:0], r_p[30:0], 1'b0}
                                       : {w_div_trial[31:0], r_p[30:0], 1'b1};

  // ---------------- FIX result ----------------
  logic [63:0] w_prod_mag, w_prod, w_mul_res, w_res;
  logic [31:0] w_q, w_rem;

`ifdef HILO_FAST_MUL_EN
  assign w_prod_mag = {32'd0, r_a} * {32'd0, r_b};
`else
  assign w_prod_mag = r_p;
`endif
  assign w_prod    = r_neg_q ? (64'd0 - w_prod_mag) : w_prod_mag;
  assign w_mul_res = !r_op[2] ? w_prod : (r_op[1] ? (r_acc - w_prod) : (r_acc + w_prod));
  assign w_q       = r_neg_q ? (32'd0 - r_p[31:0])  : r_p[31:0];
  assign w_rem     = r_neg_r ? (32'd0 - r_p[63:32]) : r_p[63:32];
  assign w_res     = r_div0     ? {r_a, 32'hFFFF_FFFF} :
                     w_r_is_div ? {w_rem, w_q} : w_mul_res;

  // ---------------- state / datapath ----------------
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state <= S_IDLE;
      r_op    <= 3'd0;
      r_a     <= 32'd0;
      r_b     <= 32'd0;
      r_p     <= 64'd0;
      r_acc   <= 64'd0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      r_div0  <= 1'b0;
      r_cnt   <= 5'd0;
      r_hi    <= 32'd0;
      r_lo    <= 32'd0;
      r_done  <= 1'b0;
      r_dbz   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_done  <= (r_state == S_FIX);
      unique case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_op    <= i_op;
            r_a     <= w_div0 ? i_rs_data : w_rs_abs;
            r_b     <= w_rt_abs;
            r_p     <= {32'd0, (w_is_div ? w_rs_abs : w_rt_abs)};
            r_acc   <= {r_hi, r_lo};
            r_neg_q <= w_rs_neg ^ w_rt_neg;
            r_neg_r <= w_rs_neg;
            r_div0  <= w_div0;
            r_cnt   <= 5'd0;
            r_dbz   <= 1'b0;
          end else begin
            // start wins over MTHI/MTLO in the same cycle
            if (i_mt_hi) r_hi <= i_mt_data;
            if (i_mt_lo) r_lo <= i_mt_data;
          end
        end
        S_CALC: begin
          r_p   <= w_r_is_div ? w_div_step : w_mul_step;
          r_cnt <= r_cnt + 5'd1;
        end
        S_FIX: begin
          r_hi <= w_res[63:32];
          r_lo <= w_res[31:0];
          if (r_div0) r_dbz <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign o_busy        = (r_state != S_IDLE);
  assign o_done        = r_done;
  assign o_div_by_zero = r_dbz;
  assign o_hi          = r_hi;
  assign o_lo          = r_lo;

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Self-checking bench for hilo_muldiv_unit: a latency-countdown model checked
// every cycle plus directed vectors with hand-computed results.
module tb_hilo_muldiv_unit;

  logic        clk = 1'b0;
  logic        reset_n, start, mt_hi, mt_lo;
  logic [2:0]  op;
  logic [31:0] rs, rt, mt_data;
  logic        o_busy, o_done, o_dbz;
  logic [31:0] o_hi, o_lo;

  hilo_muldiv_unit dut (
    .i_clk(clk), .i_reset_n(reset_n), .i_start(start), .i_op(op),
    .i_rs_data(rs), .i_rt_data(rt), .i_mt_hi(mt_hi), .i_mt_lo(mt_lo),
    .i_mt_data(mt_data), .o_busy(o_busy), .o_done(o_done),
    .o_div_by_zero(o_dbz), .o_hi(o_hi), .o_lo(o_lo)
  );

  always #5 clk = ~clk;

`ifdef HILO_FAST_MUL_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = 33;
`endif

  localparam logic [2:0] MULT = 3'd0, MULTU = 3'd1, DIV = 3'd2, DIVU = 3'd3,
                         MADD = 3'd4, MADDU = 3'd5, MSUB = 3'd6, MSUBU = 3'd7;

  int n_tests = 0, n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail < 40) $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Returns {div_by_zero, HI, LO} straight from the arithmetic definition.
  function automatic logic [64:0] f_expect(input logic [2:0] o, input logic [31:0] a,
                                           input logic [31:0] b, input logic [63:0] acc);
    longint sa, sb;
    logic [63:0] p, q, r;
    if (o == DIV || o == DIVU) begin
      if (b == 32'd0) return {1'b1, a, 32'hFFFF_FFFF};
      if (o == DIV) begin
        sa = $signed({{32{a[31]}}, a});
        sb = $signed({{32{b[31]}}, b});
        q  = 64'(sa / sb);
        r  = 64'(sa % sb);
      end else begin
        q = {32'd0, a} / {32'd0, b};
        r = {32'd0, a} % {32'd0, b};
      end
      return {1'b0, r[31:0], q[31:0]};
    end
    if (o[0] == 1'b0) begin
      sa = $signed({{32{a[31]}}, a});
      sb = $signed({{32{b[31]}}, b});
      p  = 64'(sa * sb);
    end else p = {32'd0, a} * {32'd0, b};
    if (o[2]) p = o[1] ? (acc - p) : (acc + p);
    return {1'b0, p};
  endfunction

  logic [31:0] m_hi = '0, m_lo = '0;
  logic        m_busy = 1'b0, m_done = 1'b0, m_dbz = 1'b0;
  int          m_left = 0;
  logic [64:0] m_pend = '0;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_hi <= '0; m_lo <= '0; m_busy <= 1'b0; m_done <= 1'b0;
      m_dbz <= 1'b0; m_left <= 0;
    end else begin
      m_done <= 1'b0;
      if (m_busy) begin
        if (m_left == 1) begin
          m_busy <= 1'b0; m_done <= 1'b1;
          m_hi <= m_pend[63:32]; m_lo <= m_pend[31:0]; m_dbz <= m_pend[64];
        end
        m_left <= m_left - 1;
      end else if (start) begin
        m_pend <= f_expect(op, rs, rt, {m_hi, m_lo});
        m_left <= ((op == DIV || op == DIVU) && rt == 32'd0) ? 1 :
                  (op == DIV || op == DIVU) ? 33 : MUL_LAT;
        m_busy <= 1'b1;
        m_dbz  <= 1'b0;
      end else begin
        if (mt_hi) m_hi <= mt_data;
        if (mt_lo) m_lo <= mt_data;
      end
    end
  end

  // per-cycle compare against the model
  always @(negedge clk) begin
    if (reset_n === 1'b1) begin
      chk("busy", {63'd0, o_busy}, {63'd0, m_busy});
      chk("done", {63'd0, o_done}, {63'd0, m_done});
      chk("div_by_zero", {63'd0, o_dbz}, {63'd0, m_dbz});
      chk("hi", {32'd0, o_hi}, {32'd0, m_hi});
      chk("lo", {32'd0, o_lo}, {32'd0, m_lo});
    end
  end

  // ---------------- directed stimulus ----------------
  // Called at a negedge; returns at the negedge where done is seen, so the
  // next call presents start in the done cycle (back-to-back).
  task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        output int lat);
    start = 1'b1; op = o; rs = a; rt = b;
    @(negedge clk);
    start = 1'b0;
    lat = 0;
    while (o_done !== 1'b1 && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    chk("done_seen", {63'd0, o_done}, 64'd1);
  endtask

  task automatic expect_res(input string name, input logic [31:0] hi, input logic [31:0] lo);
    chk({name, "_hi"}, {32'd0, o_hi}, {32'd0, hi});
    chk({name, "_lo"}, {32'd0, o_lo}, {32'd0, lo});
  endtask

  int lat, ndone;

  initial begin
    reset_n = 1'b0; start = 1'b0; mt_hi = 1'b0; mt_lo = 1'b0;
    op = 3'd0; rs = '0; rt = '0; mt_data = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", {63'd0, o_busy}, 64'd0);
    chk("rst_done", {63'd0, o_done}, 64'd0);
    chk("rst_dbz",  {63'd0, o_dbz},  64'd0);
    expect_res("rst", 32'd0, 32'd0);
    reset_n = 1'b1;
    @(negedge clk);

    run_op(MULT, 32'hFFFF_FFFE, 32'd3, lat);
    expect_res("mult", 32'hFFFF_FFFF, 32'hFFFF_FFFA);
    chk("mult_lat", 64'(lat), 64'(MUL_LAT));
    chk("mult_busy_at_done", {63'd0, o_busy}, 64'd0);

    run_op(MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat);
    expect_res("multu", 32'hFFFF_FFFE, 32'h0000_0001);

    run_op(DIV, 32'hFFFF_FFF9, 32'd2, lat);
    expect_res("div", 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    chk("div_lat", 64'(lat), 64'd33);

    run_op(DIVU, 32'd7, 32'd0, lat);
    expect_res("div0", 32'd7, 32'hFFFF_FFFF);
    chk("div0_flag", {63'd0, o_dbz}, 64'd1);
    chk("div0_lat", 64'(lat), 64'd1);

    run_op(DIV, 32'h8000_0000, 32'hFFFF_FFFF, lat);
    expect_res("div_ovf", 32'd0, 32'h8000_0000);
    chk("dbz_cleared", {63'd0, o_dbz}, 64'd0);

    run_op(DIV, 32'd7, 32'hFFFF_FFFE, lat);
    expect_res("div_negb", 32'd1, 32'hFFFF_FFFD);

    // MTHI 0 / MTLO 10
    @(negedge clk);
    mt_hi = 1'b1; mt_data = 32'd0;
    @(negedge clk);
    mt_hi = 1'b0; mt_lo = 1'b1; mt_data = 32'd10;
    @(negedge clk);
    mt_lo = 1'b0;
    expect_res("mt", 32'd0, 32'd10);

    run_op(MADD, 32'd4, 32'd5, lat);
    expect_res("madd", 32'd0, 32'd30);
    run_op(MSUB, 32'd40, 32'd1, lat);
    expect_res("msub", 32'hFFFF_FFFF, 32'hFFFF_FFF6);
    run_op(MSUBU, 32'hFFFF_FFFF, 32'd1, lat);
    expect_res("msubu", 32'hFFFF_FFFE, 32'hFFFF_FFF7);
    run_op(MADDU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat);
    expect_res("maddu", 32'hFFFF_FFFC, 32'hFFFF_FFF8);

    // start and MTLO together in IDLE: start wins
    mt_lo = 1'b1; mt_data = 32'd99;
    start = 1'b1; op = MULTU; rs = 32'd2; rt = 32'd3;
    @(negedge clk);
    start = 1'b0; mt_lo = 1'b0;
    lat = 0;
    while (o_done !== 1'b1 && lat < 100) begin @(negedge clk); lat++; end
    chk("start_wins_done", {63'd0, o_done}, 64'd1);
    expect_res("start_wins", 32'd0, 32'd6);

    // second start and MTLO during a busy DIV are both ignored
    @(negedge clk);
    start = 1'b1; op = DIV; rs = 32'd100; rt = 32'd7;
    @(negedge clk);
    start = 1'b0;
    ndone = 0;
    for (int c = 1; c <= 40; c++) begin
      if (c == 10) begin start = 1'b1; op = MULTU; rs = 32'd5; rt = 32'd5; end
      if (c == 11) start = 1'b0;
      if (c == 12) begin mt_lo = 1'b1; mt_data = 32'd77; end
      if (c == 13) mt_lo = 1'b0;
      @(negedge clk);
      if (o_done === 1'b1) ndone++;
    end
    chk("ignored_done_count", 64'(ndone), 64'd1);
    expect_res("ignored", 32'd2, 32'd14);

    // reset in the middle of CALC
    start = 1'b1; op = MULT; rs = 32'h1234; rt = 32'h5678;
    @(negedge clk);
    start = 1'b0;
    repeat (14) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("midrst_busy", {63'd0, o_busy}, 64'd0);
    chk("midrst_done", {63'd0, o_done}, 64'd0);
    expect_res("midrst", 32'd0, 32'd0);
    @(negedge clk);
    #2 reset_n = 1'b1;
    @(negedge clk);
    run_op(MULT, 32'd2, 32'd3, lat);
    expect_res("post_rst", 32'd0, 32'd6);
    chk("post_rst_lat", 64'(lat), 64'(MUL_LAT));

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/hilo_muldiv_unit.md
# hilo_muldiv_unit

Multi-cycle integer multiply/divide unit with architectural HI/LO registers for the mini-MIPS datapath. It sits beside the general-purpose register file in the execute/writeback path: it takes rs/rt operands read from the GPRs, runs MULT/MULTU/DIV/DIVU/MADD/MADDU/MSUB/MSUBU, and exposes HI/LO to the writeback mux for MFHI/MFLO. MTHI/MTLO write HI/LO directly. The pipeline stalls on `busy`.

## Interface
- No parameters. Data width is fixed at 32; HI/LO form a 64-bit pair.
- `clk`  in  1  rising-edge clock
- `reset_n`  in  1  asynchronous, active-low reset
- `start`  in  1  launch operation `op` on `rs_data`/`rt_data`
- `op`  in  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MADD, 101 MADDU, 110 MSUB, 111 MSUBU
- `rs_data`  in  32  multiplicand / dividend
- `rt_data`  in  32  multiplier / divisor
- `mt_hi`  in  1  write `mt_data` to HI (MTHI)
- `mt_lo`  in  1  write `mt_data` to LO (MTLO)
- `mt_data`  in  32  MTHI/MTLO data
- `busy`  out  1  operation in progress; pipeline must stall
- `done`  out  1  one-cycle pulse when HI/LO take a result
- `div_by_zero`  out  1  set by DIV/DIVU with `rt_data`=0; cleared by the next accepted `start`
- `hi`  out  32  HI register, registered
- `lo`  out  32  LO register, registered

## Operation
- FSM states:
  - IDLE: accept `start`.
  - CALC: 32 iterations, 5-bit counter.
  - FIX: sign correction and accumulate; HI/LO write; `done`=1; returns to IDLE.
- `start` in IDLE latches `op` and the operands. Signed ops latch absolute values plus the result sign. MADD*/MSUB* also latch the current {HI,LO} as the accumulator.
- Multiply: shift-add, one partial product per CALC cycle, 64-bit product.
- Divide: restoring divide, one quotient bit per CALC cycle.
  - LO is the quotient, truncated toward zero.
  - HI is the remainder, which takes the sign of the dividend.
- MADD/MADDU: {HI,LO} = acc + product. MSUB/MSUBU: {HI,LO} = acc − product. Both are mod 2^64 with no overflow flag.
- Divide by zero: CALC is skipped and the unit goes IDLE→FIX. Result is HI=`rs_data`, LO=0xFFFFFFFF, `div_by_zero`=1.
- DIV of 0x80000000 by 0xFFFFFFFF gives LO=0x80000000, HI=0.
- `start` while `busy`=1 is ignored; operands are not re-latched.
- `mt_hi`/`mt_lo` are honoured only in IDLE with `start`=0.
  - If `start` and an mt strobe are both high in IDLE, `start` wins and the mt strobe is dropped.
  - `mt_hi` and `mt_lo` together write `mt_data` to both registers.
- `reset_n` low in any state: immediate return to IDLE; the in-flight result is discarded.

## Timing
- Reset values: `hi`=0, `lo`=0, `busy`=0, `done`=0, `div_by_zero`=0.
- `start` sampled at edge E0 → `busy`=1 after E0.
- CALC runs E1..E32. FIX completes at E33: `hi`/`lo` update, `done`=1 for exactly one cycle, `busy`=0.
- Back-to-back: a new `start` may be presented in the cycle where `done`=1. It is sampled at the next edge.
- Divide by zero: `done` after E1, so latency is 1 cycle.
- `hi`/`lo` hold their old values throughout CALC; MFHI during `busy` returns the stale value, so the stall is mandatory.
- MTHI/MTLO: new value visible the cycle after the write edge.

## Configuration
- `HILO_FAST_MUL_EN` defined: all multiply-class ops (op≠010/011) bypass CALC and compute the full 64-bit product combinationally in FIX. `done` follows after E1, so latency is 1 cycle. Divide timing is unchanged.
- Undefined: every op uses the 32-cycle iterative path, latency 33 cycles.

## Test plan
- MULT rs=0xFFFFFFFE (−2), rt=3 → after 33 cycles (1 with `HILO_FAST_MUL_EN`) HI=0xFFFFFFFF, LO=0xFFFFFFFA, one `done` pulse.
- MULTU 0xFFFFFFFF × 0xFFFFFFFF → HI=0xFFFFFFFE, LO=0x00000001.
- DIV rs=−7 (0xFFFFFFF9), rt=2 → LO=0xFFFFFFFD (−3), HI=0xFFFFFFFF (−1); then DIVU 7/0 → `div_by_zero`=1, HI=7, LO=0xFFFFFFFF, `done` one cycle after `start`.
- MTHI 0, MTLO 10; MADD 4×5 → LO=30, HI=0. Then MSUB 40×1 → HI=0xFFFFFFFF, LO=0xFFFFFFF6.
- Second `start` at cycle 10 of a DIV, and `mt_lo` during `busy` → both ignored; the first result is intact and only one `done` occurs.
- Assert `reset_n`=0 at CALC cycle 15 → `busy`, `done`, `hi`, `lo` all 0 immediately; a fresh MULT 2×3 afterwards gives LO=6.
